gray_step_arbiter: RTL and testbench

//  Sequences and shares one 3-bit gray counter (Clk/Reset/En -> Output/Overflow) between two requesters.

---
 rtl/gray_step_arbiter.sv | 141 ++++++++++++++
 tb/tb_gray_step_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
//   Shares one 3-bit gray counter between two requesters. Each request asks
//   for N count steps, optionally preceded by a counter clear. Grants are
//   round-robin; completion is reported together with the counter's
//   Overflow state.
//
// Ports
//   Clk            rising-edge clock
//   Reset          asynchronous, active-low reset
//   Req0/Req1      requests, held high until acknowledged
//   Steps0/Steps1  requested step count, sampled at acceptance
//   Clr0/Clr1      clear counter before stepping, sampled at acceptance
//   Ack0/Ack1      one-cycle pulse: request accepted
//   Done0/Done1    one-cycle pulse: requested steps completed
//   Done_Ovf       counter Overflow during the Done cycle, else 0
//   Busy           transaction in progress
//   Owner          current / last grant holder
//   Cnt_En         counter enable
//   Cnt_Clr        counter synchronous clear (active-high)
//   Cnt_Overflow   counter Overflow flag
module gray_step_arbiter #(
    parameter int STEP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [STEP_W-1:0] Steps0,
    input  logic [STEP_W-1:0] Steps1,
    input  logic              Clr0,
    input  logic              Clr1,
    output logic              Ack0,
    output logic              Ack1,
    output logic              Done0,
    output logic              Done1,
    output logic              Done_Ovf,
    output logic              Busy,
    output logic              Owner,
    output logic              Cnt_En,
    output logic              Cnt_Clr,
    input  logic              Cnt_Overflow
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] rem, rem_nxt;
    logic              owner_q, owner_nxt;
    logic              prio, prio_nxt;
    logic              ack_q, ack_nxt;

    logic              win;
    logic [STEP_W-1:0] win_steps;
    logic              win_clr;

    // Single requester wins outright; a tie goes to the one named by prio.
    always_comb begin
        win       = (Req0 && Req1) ? prio : Req1;
        win_steps = win ? Steps1 : Steps0;
        win_clr   = win ? Clr1   : Clr0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            rem     <= '0;
            owner_q <= 1'b0;
            prio    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            owner_q <= owner_nxt;
            prio    <= prio_nxt;
            ack_q   <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        owner_nxt = owner_q;
        prio_nxt  = prio;
        ack_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    owner_nxt = win;
                    rem_nxt   = win_steps;
                    ack_nxt   = 1'b1;
                    if (win_clr)
                        state_nxt = CLEAR;
                    else if (win_steps != '0)
                        state_nxt = RUN;
                    else
                        state_nxt = SETTLE;
                end
            end
            CLEAR: begin
                state_nxt = (rem != '0) ? RUN : SETTLE;
            end
            RUN: begin
                rem_nxt = rem - 1'b1;
                if (rem == STEP_W'(1))
                    state_nxt = SETTLE;
            end
            // Counter Overflow is registered: one extra cycle lets it
            // reflect the final count before it is reported.
            SETTLE: begin
                state_nxt = DONE;
            end
            DONE: begin
                prio_nxt  = ~owner_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        Busy     = (state != IDLE);
        Cnt_En   = (state == RUN);
        Cnt_Clr  = (state == CLEAR);
        Done0    = (state == DONE) && !owner_q;
        Done1    = (state == DONE) &&  owner_q;
        Done_Ovf = (state == DONE) && Cnt_Overflow;
        Ack0     = ack_q && !owner_q;
        Ack1     = ack_q &&  owner_q;
        Owner    = owner_q;
    end

endmodule

// File: tb/tb_gray_step_arbiter.sv
// tb_gray_step_arbiter
//   Directed bench for gray_step_arbiter. A small behavioural 3-bit gray
//   counter (sync clear, enable, sticky registered Overflow at value 7) is
//   attached to the arbiter's counter-control outputs.
module tb_gray_step_arbiter;

    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [STEP_W-1:0] steps0 = '0, steps1 = '0;
    logic              clr0 = 1'b0, clr1 = 1'b0;
    logic              ack0, ack1, done0, done1, done_ovf, busy, owner;
    logic              cnt_en, cnt_clr;

    // behavioural counter
    logic [2:0] cnt_b = 3'd0;
    logic       cnt_ovf = 1'b0;
    logic [2:0] cnt_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr) begin
            cnt_b   <= 3'd0;
            cnt_ovf <= 1'b0;
        end else begin
            if (cnt_b == 3'd7) cnt_ovf <= 1'b1;
            if (cnt_en) cnt_b <= cnt_b + 3'd1;
        end
    end
    assign cnt_out = cnt_b ^ (cnt_b >> 1);

    gray_step_arbiter #(.STEP_W(STEP_W)) dut (
        .Clk          (clk),
        .Reset        (reset),
        .Req0         (req0),
        .Req1         (req1),
        .Steps0       (steps0),
        .Steps1       (steps1),
        .Clr0         (clr0),
        .Clr1         (clr1),
        .Ack0         (ack0),
        .Ack1         (ack1),
        .Done0        (done0),
        .Done1        (done1),
        .Done_Ovf     (done_ovf),
        .Busy         (busy),
        .Owner        (owner),
        .Cnt_En       (cnt_en),
        .Cnt_Clr      (cnt_clr),
        .Cnt_Overflow (cnt_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to the first IDLE cycle after Done.
    // Cycle c counts from the first cycle after the acceptance edge.
    task automatic txn(input bit id, input int n, input bit clr, input bit exp_ovf, input string tag);
        int en_cnt = 0, en_out = 0, clr_cnt = 0, clr_bad = 0, both = 0;
        int done_cnt = 0, done_cyc = 0, ovf_bad = 0, ack_extra = 0;
        int other = 0, busy_bad = 0, last;
        logic ovf_at_done = 1'b0;
        logic my_ack, my_done, oth;
        if (id == 1'b0) begin
            req0 = 1'b1; steps0 = STEP_W'(n); clr0 = clr;
        end else begin
            req1 = 1'b1; steps1 = STEP_W'(n); clr1 = clr;
        end
        step();
        chk({tag, ".ack"},   id ? ack1 : ack0, 1);
        chk({tag, ".owner"}, owner, 32'(id));
        if (id == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        last = n + clr + 3;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            my_ack  = id ? ack1 : ack0;
            my_done = id ? done1 : done0;
            oth     = id ? (ack0 || done0) : (ack1 || done1);
            if (cnt_en === 1'b1) begin
                en_cnt++;
                if (c < 1 + clr || c > n + clr) en_out++;
            end
            if (cnt_clr === 1'b1) begin
                clr_cnt++;
                if (c != 1) clr_bad++;
            end
            if (cnt_en === 1'b1 && cnt_clr === 1'b1) both++;
            if (my_done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                ovf_at_done = done_ovf;
            end else if (done_ovf !== 1'b0) begin
                ovf_bad++;
            end
            if (c > 1 && my_ack !== 1'b0) ack_extra++;
            if (oth !== 1'b0) other++;
            if (busy !== (c <= n + clr + 2)) busy_bad++;
        end
        chk({tag, ".en_count"},   en_cnt, n);
        chk({tag, ".en_window"},  en_out, 0);
        chk({tag, ".clr_count"},  clr_cnt, 32'(clr));
        chk({tag, ".clr_window"}, clr_bad, 0);
        chk({tag, ".en_clr_both"}, both, 0);
        chk({tag, ".done_count"}, done_cnt, 1);
        chk({tag, ".done_cycle"}, done_cyc, n + clr + 2);
        chk({tag, ".done_ovf"},   ovf_at_done, 32'(exp_ovf));
        chk({tag, ".ovf_stray"},  ovf_bad, 0);
        chk({tag, ".ack_extra"},  ack_extra, 0);
        chk({tag, ".other_req"},  other, 0);
        chk({tag, ".busy"},       busy_bad, 0);
        chk({tag, ".owner_hold"}, owner, 32'(id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #3;
        chk("rst.outputs", {ack0, ack1, done0, done1, done_ovf, busy, owner, cnt_en, cnt_clr}, 0);
        step();
        step();
        chk("rst.held", {ack0, ack1, done0, done1, done_ovf, busy, owner, cnt_en, cnt_clr}, 0);
        reset = 1'b1;

        // basic clear + 3 steps
        txn(1'b0, 3, 1'b1, 1'b0, "t1");
        chk("t1.cnt_out", cnt_out, 3'b010);

        // overflow boundary
        txn(1'b0, 6, 1'b1, 1'b0, "t2_6");
        txn(1'b0, 7, 1'b1, 1'b1, "t2_7");
        txn(1'b0, 8, 1'b1, 1'b1, "t2_8");
        chk("t2_8.cnt_out", cnt_out, 3'b000);

        // tie after reset goes to 0; held Req1 follows one IDLE cycle later
        reset = 1'b0;
        #2;
        chk("t3.rst_busy", busy, 0);
        chk("t3.rst_owner", owner, 0);
        reset = 1'b1;
        req1 = 1'b1; steps1 = 4'd2; clr1 = 1'b1;
        txn(1'b0, 1, 1'b0, 1'b1, "t3_a");
        txn(1'b1, 2, 1'b1, 1'b0, "t3_b");
        req1 = 1'b1; steps1 = 4'd1; clr1 = 1'b0;
        txn(1'b0, 1, 1'b1, 1'b0, "t3_prio");
        req1 = 1'b0;

        // zero-step request
        txn(1'b1, 0, 1'b0, 1'b0, "t4");

        // max steps from counter value 3 with the other requester waiting
        txn(1'b1, 3, 1'b1, 1'b0, "t6_pre");
        chk("t6_pre.cnt_out", cnt_out, 3'b010);
        req1 = 1'b1; steps1 = 4'd5; clr1 = 1'b0;
        txn(1'b0, 15, 1'b0, 1'b1, "t6");
        req1 = 1'b0;
        chk("t6.cnt_out", cnt_out, 3'b011);

        // reset during RUN (rem=5); prio was 1 before the reset
        req1 = 1'b1; steps1 = 4'd8; clr1 = 1'b0;
        step();
        chk("t5.ack1", ack1, 1);
        chk("t5.owner1", owner, 1);
        req1 = 1'b0;
        step();
        step();
        step();
        chk("t5.run_en", cnt_en, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5.rst_en", cnt_en, 0);
        chk("t5.rst_busy", busy, 0);
        chk("t5.rst_owner", owner, 0);
        chk("t5.rst_pulses", {ack0, ack1, done0, done1, done_ovf, cnt_clr}, 0);
        chk("t5.cnt_kept", cnt_out, 3'b111);
        @(negedge clk);
        reset = 1'b1;
        req1 = 1'b1; steps1 = 4'd1; clr1 = 1'b0;
        txn(1'b0, 2, 1'b0, 1'b1, "t5_post");
        req1 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
